btn_press_ctrl: RTL
===================

BTN_PRESS_CTRL -- requirements
Module: btn_press_ctrl

Sits directly downstream of debouncer: consumes o_btn_db, classifies short/long presses, issues camera-reconfig request.

Interface
REQ-001 Parameter LONG_CYCLES, default 100_000_000, consecutive high samples (1 s @ 100 MHz) that make a press "long"; legal range >= 2.
REQ-002 i_clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_btn_db  input  1  debounced button level from debouncer, synchronous to i_clk, no further synchronisation.
REQ-005 i_cfg_ack  input  1  config controller accepts pending request; sampled each edge.
REQ-006 o_short  output  1  one-cycle pulse per short press.
REQ-007 o_long  output  1  one-cycle pulse per long press.
REQ-008 o_cfg_req  output  1  level request to camera config controller, held until acknowledged.
REQ-009 o_drop  output  1  one-cycle pulse when a short press arrives while o_cfg_req is already high.
REQ-010 o_mode  output  1  mode flag toggled by each long press.

Function
REQ-011 Registered copy btn_q of i_btn_db SHALL be kept; rise = i_btn_db & ~btn_q, fall = ~i_btn_db & btn_q, both evaluated at the same edge.
REQ-012 FSM states SHALL be IDLE, HELD, LONG_WAIT; reset state IDLE.
REQ-013 IDLE: on rise -> HELD, hold counter loaded with 1; otherwise stay.
REQ-014 HELD: i_btn_db high -> counter +1 each edge; at the edge where counter would reach LONG_CYCLES -> LONG_WAIT, o_long high for the following cycle only, o_mode toggles at that same edge.
REQ-015 HELD: fall before LONG_CYCLES reached -> IDLE, o_short high for the following cycle only.
REQ-016 LONG_WAIT: no pulses; fall -> IDLE; counter frozen, never wraps.
REQ-017 Counter width SHALL be $clog2(LONG_CYCLES+1) bits; counter cleared on entry to IDLE.
REQ-018 Press held exactly LONG_CYCLES-1 samples SHALL yield o_short; exactly LONG_CYCLES samples SHALL yield o_long; never both for one press.
REQ-019 o_cfg_req SHALL be set at the edge that asserts o_short; cleared at the edge after i_cfg_ack is sampled high with o_cfg_req high.
REQ-020 i_cfg_ack while o_cfg_req low SHALL be ignored.
REQ-021 Short press while o_cfg_req high (and no ack at that edge): o_cfg_req stays high, o_drop pulses one cycle, o_short still pulses.
REQ-022 Ack and new short press at the same edge: new request wins, o_cfg_req stays high, o_drop not asserted.
REQ-023 Long presses SHALL NOT affect o_cfg_req or o_drop.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 i_rst high at an edge: state IDLE, counter 0, btn_q 1, o_short 0, o_long 0, o_cfg_req 0, o_drop 0, o_mode 0.
REQ-026 btn_q reset to 1 so a button held through reset produces no event until released and pressed again.
REQ-027 Reset mid-press or with o_cfg_req pending SHALL abandon the press and drop the request with no pulse generated.

Verification (LONG_CYCLES = 8)
REQ-028 i_btn_db high 3 cycles then low -> exactly one o_short pulse the cycle after the falling sample, o_cfg_req rises same cycle, o_mode stays 0.
REQ-029 i_btn_db high 7 cycles -> o_short; high 8 cycles -> o_long one cycle, o_mode 0->1, no o_short on release; held 50 cycles -> still a single o_long.
REQ-030 Short press, no ack, second short press -> o_drop one pulse, o_cfg_req stays 1; then i_cfg_ack 1 cycle -> o_cfg_req 0 next cycle.
REQ-031 i_cfg_ack asserted at the same edge as a new short press -> o_cfg_req remains 1, o_drop 0.
REQ-032 i_btn_db high during and after i_rst deassert -> no pulses; release then 3-cycle press -> one o_short.
REQ-033 i_rst asserted during HELD at count 5 -> all outputs 0, no o_short/o_long on subsequent release.

Source files
------------

// File: rtl/btn_press_ctrl_if.sv
// Signal bundle between the button press classifier and its neighbours:
// debounced button and config ack in, press pulses, config request and mode out.
interface btn_press_ctrl_if;
  logic i_btn_db;
  logic i_cfg_ack;
  logic o_short;
  logic o_long;
  logic o_cfg_req;
  logic o_drop;
  logic o_mode;

  modport master (
    output i_btn_db, i_cfg_ack,
    input  o_short, o_long, o_cfg_req, o_drop, o_mode
  );

  modport slave (
    input  i_btn_db, i_cfg_ack,
    output o_short, o_long, o_cfg_req, o_drop, o_mode
  );
endinterface

// File: rtl/btn_press_ctrl.sv
// Classifies debounced button presses as short or long, raises a held camera
// reconfig request on short presses and toggles a mode flag on long presses.
module btn_press_ctrl #(
  parameter int unsigned LONG_CYCLES = 100_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  btn_press_ctrl_if.slave    bus
);

  localparam int unsigned CW = $clog2(LONG_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          cfg_req_q, cfg_req_d;
  logic          drop_q, drop_d;
  logic          mode_q, mode_d;
  logic          rise, fall;

  assign rise = bus.i_btn_db & ~btn_q;
  assign fall = ~bus.i_btn_db & btn_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HELD;
          cnt_d   = CW'(1);
        end
      end
      HELD: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else if (cnt_q == CW'(LONG_CYCLES - 1)) begin
          // This sample completes a long press; the count then freezes.
          state_d = LONG_WAIT;
          cnt_d   = CW'(LONG_CYCLES);
          long_d  = 1'b1;
          mode_d  = ~mode_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG_WAIT: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A fresh short press outranks an ack landing on the same edge.
  always_comb begin
    cfg_req_d = cfg_req_q;
    drop_d    = 1'b0;
    if (short_d) begin
      cfg_req_d = 1'b1;
      drop_d    = cfg_req_q & ~bus.i_cfg_ack;
    end else if (cfg_req_q && bus.i_cfg_ack) begin
      cfg_req_d = 1'b0;
    end
  end

  // btn_q resets high so a button held through reset must be released first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      btn_q     <= 1'b1;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      cfg_req_q <= 1'b0;
      drop_q    <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= bus.i_btn_db;
      short_q   <= short_d;
      long_q    <= long_d;
      cfg_req_q <= cfg_req_d;
      drop_q    <= drop_d;
      mode_q    <= mode_d;
    end
  end

  assign bus.o_short   = short_q;
  assign bus.o_long    = long_q;
  assign bus.o_cfg_req = cfg_req_q;
  assign bus.o_drop    = drop_q;
  assign bus.o_mode    = mode_q;

endmodule
